// File: rtl/timer_device_pkg.sv
// Shared definitions for the memory-mapped countdown timer.
// Holds the FSM state encoding, register word offsets, CTRL bit
// positions and mode constants used by the RTL and the testbench.
package timer_device_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_CNT  = 2'd2,
    ST_INT  = 2'd3
  } state_e;

  // Word offsets decoded from Addr[3:2].
  localparam logic [1:0] OFF_CTRL   = 2'd0;
  localparam logic [1:0] OFF_PRESET = 2'd1;
  localparam logic [1:0] OFF_COUNT  = 2'd2;
  localparam logic [1:0] OFF_RSVD   = 2'd3;

  // CTRL bit positions.
  localparam int CTRL_EN     = 0;
  localparam int CTRL_MODE_L = 1;
  localparam int CTRL_MODE_H = 2;
  localparam int CTRL_IM     = 3;

  // Mode values; 2 and 3 fall back to one-shot behaviour.
  localparam logic [1:0] MODE_ONESHOT  = 2'd0;
  localparam logic [1:0] MODE_PERIODIC = 2'd1;

endpackage

// File: rtl/timer_device_if.sv
// Bridge-side register bus of one timer instance.
//   Addr [31:0] : device address, only [3:2] is decoded by the timer
//   WE          : full-word write enable
//   Din  [31:0] : write data
//   Dout [31:0] : combinational read data
//   IRQ         : interrupt request toward the CPU
// master = bridge side, slave = timer side.
interface timer_device_if;
  logic [31:0] Addr;
  logic        WE;
  logic [31:0] Din;
  logic [31:0] Dout;
  logic        IRQ;

  modport master (output Addr, output WE, output Din, input Dout, input IRQ);
  modport slave  (input Addr, input WE, input Din, output Dout, output IRQ);
endinterface

// File: rtl/timer_device.sv
// Memory-mapped countdown timer with one-shot and periodic modes.
// Ports:
//   clk   : system clock, rising edge
//   reset : synchronous, active-high reset
//   bus   : slave side of timer_device_if (Addr/WE/Din in, Dout/IRQ out)
// Register map (Addr[3:2]): 0 CTRL {IM, MODE[1:0], EN}, 1 PRESET,
// 2 COUNT (read-only), 3 reserved (reads 0).
module timer_device
  import timer_device_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic           clk,
  input  logic           reset,
  timer_device_if.slave  bus
);

  logic [3:0]       ctrl_q,        ctrl_d;
  logic [CNT_W-1:0] preset_q,      preset_d;
  logic [CNT_W-1:0] count_q,       count_d;
  state_e           state_q,       state_d;
  logic             irq_pending_q, irq_pending_d;

  logic [1:0] word_sel;
  logic       wr_ctrl;
  logic       wr_preset;
  logic       enable;
  logic [1:0] mode;

  assign word_sel  = bus.Addr[3:2];
  assign wr_ctrl   = bus.WE && (word_sel == OFF_CTRL);
  assign wr_preset = bus.WE && (word_sel == OFF_PRESET);
  assign enable    = ctrl_q[CTRL_EN];
  assign mode      = ctrl_q[CTRL_MODE_H:CTRL_MODE_L];

  // The bridge guarantees the address window, so the remaining bits
  // carry no information for this block.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{bus.Addr[31:4], bus.Addr[1:0]};

  // The FSM looks only at the *_q values, so it always sees the
  // registers as they were before this edge's CPU write.
  always_comb begin
    ctrl_d        = ctrl_q;
    preset_d      = preset_q;
    count_d       = count_q;
    state_d       = state_q;
    irq_pending_d = irq_pending_q;

    if (wr_preset) preset_d = CNT_W'(bus.Din);
    // Acknowledge first so that a set from the FSM below overrides it.
    if (wr_ctrl) irq_pending_d = 1'b0;

    unique case (state_q)
      ST_IDLE: if (enable) state_d = ST_LOAD;
      ST_LOAD: begin
        count_d = preset_q;
        state_d = ST_CNT;
      end
      ST_CNT: begin
        if (!enable) begin
          state_d = ST_IDLE;
        end else if (count_q == '0) begin
          state_d       = ST_INT;
          irq_pending_d = 1'b1;
        end else begin
          count_d = count_q - CNT_W'(1);
        end
      end
      ST_INT: begin
        if (mode == MODE_PERIODIC) begin
          irq_pending_d = 1'b0;
          state_d       = ST_LOAD;
        end else begin
          ctrl_d[CTRL_EN] = 1'b0;
          state_d         = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // A CPU write to CTRL overrides the hardware Enable clear.
    if (wr_ctrl) ctrl_d = bus.Din[3:0];
  end

  // NOTE: non-blocking assignments in clocked logic so every flop samples
  // the pre-edge values; blocking here would create ordering races.
  always_ff @(posedge clk) begin
    if (reset) begin
      ctrl_q        <= '0;
      preset_q      <= '0;
      count_q       <= '0;
      state_q       <= ST_IDLE;
      irq_pending_q <= 1'b0;
    end else begin
      ctrl_q        <= ctrl_d;
      preset_q      <= preset_d;
      count_q       <= count_d;
      state_q       <= state_d;
      irq_pending_q <= irq_pending_d;
    end
  end

  // NOTE: every path assigns rd_data, so the read mux stays purely
  // combinational with no inferred latch.
  logic [31:0] rd_data;
  always_comb begin
    rd_data = '0;
    unique case (word_sel)
      OFF_CTRL:   rd_data = {28'd0, ctrl_q};
      OFF_PRESET: rd_data = 32'(preset_q);
      OFF_COUNT:  rd_data = 32'(count_q);
      default:    rd_data = '0;
    endcase
  end

  assign bus.Dout = rd_data;
  assign bus.IRQ  = ctrl_q[CTRL_IM] & irq_pending_q;

endmodule

// File: doc/timer_device.md
Name: timer_device

Overview:
- Memory-mapped countdown timer that sits on the device side of the CPU/device bridge, one instance per address window (Timer0 at 0x7f00, Timer1 at 0x7f10).
- Accepts register writes and serves register reads over the bridge's shared address/write-data bus. Each instance has its own write enable and read-data return.
- Raises an interrupt request toward the CPU's exception logic when the count expires.
- Supports a one-shot mode (mode 0) and an auto-reload periodic mode (mode 1).

Parameters:
- CNT_W, 32, width of PRESET and COUNT registers.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- Addr  input  32  device address from the bridge. Only bits [3:2] are decoded; the bridge guarantees the window.
- WE  input  1  write enable from the bridge. Full-word writes only.
- Din  input  32  write data from the bridge.
- Dout  output  32  combinational read data for the word selected by Addr[3:2].
- IRQ  output  1  interrupt request, equal to CTRL.IM AND irq_pending.

Behaviour:
- Register map, selected by Addr[3:2]:
  - 0: CTRL, read/write. Bit0 = Enable, bits[2:1] = Mode, bit3 = IM (interrupt mask). Bits [31:4] read as 0 and are dropped on write.
  - 1: PRESET, read/write, full CNT_W bits.
  - 2: COUNT, read-only; writes are ignored.
  - 3: reserved; reads return 0 and writes are ignored.
- Mode values 2 and 3 behave as mode 0.
- Reset: CTRL=0, PRESET=0, COUNT=0, state=IDLE, irq_pending=0. IRQ is 0 and Dout follows Addr.
- Read latency is 0 (combinational). Write latency is 1 (visible on Dout after the edge).
- The FSM samples register values from before the current edge's CPU write.
- FSM states and transitions:
  - IDLE: if Enable, go to LOAD; otherwise stay. COUNT holds.
  - LOAD: COUNT <= PRESET, go to CNT. This load does not check Enable.
  - CNT: if !Enable, go to IDLE with COUNT frozen. Else if COUNT==0, go to INT and set irq_pending. Else COUNT <= COUNT-1.
  - INT, mode 0: hardware clears Enable and goes to IDLE. irq_pending stays set.
  - INT, mode 1: irq_pending is cleared at this exit edge (it was high for exactly one cycle) and the FSM goes straight to LOAD.
- Resulting timing:
  - Period in mode 1 is PRESET+3 cycles.
  - PRESET=0 reaches INT 2 cycles after entering LOAD.
  - Decrement never wraps below 0.
- irq_pending clears on any CPU write to CTRL (mode-0 acknowledge), or on reset.
- A PRESET write during CNT does not disturb COUNT. It takes effect at the next LOAD.
- Simultaneous events:
  - A CPU write to CTRL in the same edge as the hardware Enable-clear in INT: the CPU write wins and CTRL takes Din[3:0].
  - irq_pending being set and a CTRL write in the same edge: the set wins.
- Reset asserted mid-count returns everything to reset values on that edge, regardless of state.

Decomposition:
- Shared package holds:
  - state encoding (IDLE, LOAD, CNT, INT, 2 bits);
  - word offsets (CTRL=0, PRESET=1, COUNT=2);
  - CTRL bit positions (EN=0, MODE=2:1, IM=3);
  - mode constants (ONESHOT=0, PERIODIC=1).
- Single module; no sub-module is natural. Register file, FSM and read mux fit in one block.

Test Plan:
- Reset, then read every offset: Dout=0 at offsets 0, 1, 2 and 3. IRQ=0.
- One-shot countdown:
  - Stimulus: write PRESET=3, then CTRL=0x9 at edge 0.
  - COUNT reads 3 after edge 2, then 2, 1, 0 after edges 3-5.
  - IRQ rises after edge 6. CTRL reads 0x8 after edge 7 while IRQ stays 1.
  - Write CTRL=0x8: IRQ drops next cycle.
- Periodic mode:
  - Stimulus: PRESET=3, CTRL=0xB.
  - IRQ is a single-cycle pulse after edges 6, 12 and 18.
  - COUNT reloads to 3 after edges 8 and 14.
- Mask and disable:
  - CTRL=0x1 with PRESET=2: irq_pending sets but IRQ stays 0.
  - Separately, clearing Enable during CNT at COUNT=5 freezes COUNT at 5 and the FSM returns to IDLE.
  - Re-enabling reloads COUNT from PRESET.
- Write corner cases:
  - A write to COUNT or offset 3 leaves all registers unchanged.
  - A PRESET=7 write mid-count leaves the current countdown unchanged; the next mode-1 reload loads 7.
  - CTRL write in the INT cycle of mode 0 with Din=0x3: CTRL reads 0x3 afterwards.
- Reset asserted during CNT at COUNT=10: the next cycle shows all reads 0, IRQ 0, and state IDLE.
